// File: rtl/bullet_collide_mp.sv
// Bullet/collision resolver for N players: per-pixel explosion and wall flags,
// plus a per-frame shooter/victim hit matrix resolved into lives, kills and game state.
module bullet_collide_mp #(
   parameter int NUM_PLAYERS   = 4,
   parameter int START_LIVES   = 3,
   parameter int LIVES_W       = 2,
   parameter int SCORE_W       = 8,
   parameter int INVULN_FRAMES = 60
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic                               frame_end_i,
   input  logic                               restart_i,
   input  logic [NUM_PLAYERS-1:0]             player_box_i,
   input  logic [NUM_PLAYERS-1:0]             player_bullet_i,
   input  logic                               all_hard_block_i,
   input  logic                               destroyable_block_i,
   output logic [NUM_PLAYERS-1:0]             bullet_explode_o,
   output logic                               bullet_collide_wall_o,
   output logic [NUM_PLAYERS-1:0]             player_hit_o,
   output logic [NUM_PLAYERS-1:0]             player_alive_o,
   output logic [NUM_PLAYERS-1:0]             player_invuln_o,
   output logic [NUM_PLAYERS*LIVES_W-1:0]     player_lives_o,
   output logic [NUM_PLAYERS*SCORE_W-1:0]     player_score_o,
   output logic                               game_over_o,
   output logic                               winner_valid_o,
   output logic [$clog2(NUM_PLAYERS)-1:0]     winner_o
);

   localparam int INVULN_W  = $clog2(INVULN_FRAMES + 1);
   localparam int PID_W     = $clog2(NUM_PLAYERS);
   localparam int SCORE_MAX = (1 << SCORE_W) - 1;

   typedef enum logic [1:0] {ST_PLAY, ST_RESOLVE, ST_OVER} state_e;

   state_e state_q, state_d;
   logic [NUM_PLAYERS-1:0][NUM_PLAYERS-1:0] hit_q, hit_d;   // [victim][shooter]
   logic [NUM_PLAYERS-1:0][NUM_PLAYERS-1:0] res_q, res_d;
   logic [NUM_PLAYERS-1:0][LIVES_W-1:0]     lives_q, lives_d;
   logic [NUM_PLAYERS-1:0][SCORE_W-1:0]     score_q, score_d;
   logic [NUM_PLAYERS-1:0][INVULN_W-1:0]    invuln_q, invuln_d;
   logic [NUM_PLAYERS-1:0]                  player_hit_q, player_hit_d;
   logic                                    game_over_q, game_over_d;
   logic                                    winner_valid_q, winner_valid_d;
   logic [PID_W-1:0]                        winner_q, winner_d;

   logic [NUM_PLAYERS-1:0]                  alive, invuln_act, tank_near;
   logic [NUM_PLAYERS-1:0][NUM_PLAYERS-1:0] new_hit;
   logic [PID_W-1:0]                        last_alive;
   int                                      kills, total, n_alive;

   always_comb begin
      for (int p = 0; p < NUM_PLAYERS; p++) begin
         alive[p]      = (lives_q[p] != '0);
         invuln_act[p] = (invuln_q[p] != '0);
      end
   end

   // A bullet never explodes on its own tank; dead tanks are transparent.
   always_comb begin
      tank_near = '0;
      new_hit   = '0;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
         for (int q = 0; q < NUM_PLAYERS; q++) begin
            if (q != p) begin
               tank_near[p] = tank_near[p] | (player_box_i[q] & alive[q]);
               new_hit[p][q] = player_box_i[p] & player_bullet_i[q] & alive[p] & ~invuln_act[p];
            end
         end
      end
      bullet_explode_o = player_bullet_i & ({NUM_PLAYERS{all_hard_block_i}} | tank_near);
   end

   assign bullet_collide_wall_o = destroyable_block_i & (|player_bullet_i);

   always_comb begin
      state_d        = state_q;
      hit_d          = hit_q;
      res_d          = res_q;
      lives_d        = lives_q;
      score_d        = score_q;
      invuln_d       = invuln_q;
      player_hit_d   = '0;
      game_over_d    = game_over_q;
      winner_valid_d = winner_valid_q;
      winner_d       = winner_q;
      last_alive     = '0;
      kills          = 0;
      total          = 0;
      n_alive        = 0;
      case (state_q)
         ST_PLAY: begin
            hit_d = hit_q | new_hit;
            if (frame_end_i) begin
               res_d = hit_q | new_hit;
               hit_d = '0;
               for (int v = 0; v < NUM_PLAYERS; v++) player_hit_d[v] = |res_d[v];
               state_d = ST_RESOLVE;
            end
         end
         ST_RESOLVE: begin
            // Pixels seen here already belong to the next frame.
            hit_d = hit_q | new_hit;
            res_d = '0;
            for (int v = 0; v < NUM_PLAYERS; v++) begin
               if (|res_q[v]) begin
                  if (lives_q[v] != '0) lives_d[v] = lives_q[v] - LIVES_W'(1);
                  invuln_d[v] = INVULN_W'(INVULN_FRAMES);
               end else if (invuln_act[v]) begin
                  invuln_d[v] = invuln_q[v] - INVULN_W'(1);
               end
            end
            for (int s = 0; s < NUM_PLAYERS; s++) begin
               kills = 0;
               for (int v = 0; v < NUM_PLAYERS; v++) if (res_q[v][s]) kills++;
               total = int'(score_q[s]) + kills;
               if (total > SCORE_MAX) total = SCORE_MAX;
               score_d[s] = SCORE_W'(total);
            end
            for (int p = 0; p < NUM_PLAYERS; p++) begin
               if (lives_d[p] != '0) begin
                  n_alive++;
                  last_alive = PID_W'(p);
               end
            end
            if (n_alive <= 1) begin
               state_d        = ST_OVER;
               game_over_d    = 1'b1;
               winner_valid_d = (n_alive == 1);
               winner_d       = (n_alive == 1) ? last_alive : '0;
            end else begin
               state_d = ST_PLAY;
            end
         end
         ST_OVER: begin
            hit_d = '0;
            if (restart_i) begin
               state_d        = ST_PLAY;
               res_d          = '0;
               lives_d        = {NUM_PLAYERS{LIVES_W'(START_LIVES)}};
               score_d        = '0;
               invuln_d       = '0;
               game_over_d    = 1'b0;
               winner_valid_d = 1'b0;
               winner_d       = '0;
            end
         end
         default: state_d = ST_PLAY;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q        <= ST_PLAY;
         hit_q          <= '0;
         res_q          <= '0;
         lives_q        <= {NUM_PLAYERS{LIVES_W'(START_LIVES)}};
         score_q        <= '0;
         invuln_q       <= '0;
         player_hit_q   <= '0;
         game_over_q    <= 1'b0;
         winner_valid_q <= 1'b0;
         winner_q       <= '0;
      end else begin
         state_q        <= state_d;
         hit_q          <= hit_d;
         res_q          <= res_d;
         lives_q        <= lives_d;
         score_q        <= score_d;
         invuln_q       <= invuln_d;
         player_hit_q   <= player_hit_d;
         game_over_q    <= game_over_d;
         winner_valid_q <= winner_valid_d;
         winner_q       <= winner_d;
      end
   end

   assign player_hit_o    = player_hit_q;
   assign player_alive_o  = alive;
   assign player_invuln_o = invuln_act;
   assign player_lives_o  = lives_q;
   assign player_score_o  = score_q;
   assign game_over_o     = game_over_q;
   assign winner_valid_o  = winner_valid_q;
   assign winner_o        = winner_q;

endmodule

// File: tb/tb_bullet_collide_mp.sv
// Bench for bullet_collide_mp: per-cycle expected outputs from a frame-level game
// model are queued by the driver and compared by an independent negedge monitor.
module tb_bullet_collide_mp;
  localparam int N     = 4;
  localparam int LW    = 2;
  localparam int SW    = 2;
  localparam int START = 3;
  localparam int INV   = 60;
  localparam int PW    = 2;
  localparam int SMAX  = (1 << SW) - 1;
  localparam int EW    = N + 1 + N + N + N + N*LW + N*SW + 1 + 1 + PW;

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic frame_end_i = 1'b0;
  logic restart_i = 1'b0;
  logic [N-1:0] player_box_i = '0;
  logic [N-1:0] player_bullet_i = '0;
  logic all_hard_block_i = 1'b0;
  logic destroyable_block_i = 1'b0;
  logic [N-1:0] bullet_explode_o;
  logic bullet_collide_wall_o;
  logic [N-1:0] player_hit_o, player_alive_o, player_invuln_o;
  logic [N*LW-1:0] player_lives_o;
  logic [N*SW-1:0] player_score_o;
  logic game_over_o, winner_valid_o;
  logic [PW-1:0] winner_o;

  bullet_collide_mp #(
    .NUM_PLAYERS(N), .START_LIVES(START), .LIVES_W(LW), .SCORE_W(SW), .INVULN_FRAMES(INV)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .frame_end_i(frame_end_i), .restart_i(restart_i),
    .player_box_i(player_box_i), .player_bullet_i(player_bullet_i),
    .all_hard_block_i(all_hard_block_i), .destroyable_block_i(destroyable_block_i),
    .bullet_explode_o(bullet_explode_o), .bullet_collide_wall_o(bullet_collide_wall_o),
    .player_hit_o(player_hit_o), .player_alive_o(player_alive_o),
    .player_invuln_o(player_invuln_o), .player_lives_o(player_lives_o),
    .player_score_o(player_score_o), .game_over_o(game_over_o),
    .winner_valid_o(winner_valid_o), .winner_o(winner_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [EW-1:0] exp_q[$];

  // game model: 0 = playing, 1 = resolving, 2 = game over
  int m_lives[N];
  int m_score[N];
  int m_inv[N];
  bit m_pend[N][N];   // [victim][shooter], hits of the frame in progress
  bit m_frame[N][N];  // hits of the frame being resolved
  int m_phase;
  bit m_wv;
  int m_win;

  function automatic void model_reset();
    for (int p = 0; p < N; p++) begin
      m_lives[p] = START;
      m_score[p] = 0;
      m_inv[p] = 0;
      for (int s = 0; s < N; s++) begin
        m_pend[p][s] = 1'b0;
        m_frame[p][s] = 1'b0;
      end
    end
    m_phase = 0;
    m_wv = 1'b0;
    m_win = 0;
  endfunction

  function automatic logic [EW-1:0] model_expect(input logic [N-1:0] box, bul, input logic hard, des);
    logic [N-1:0] ex, hit, al, iv;
    logic [N*LW-1:0] lv;
    logic [N*SW-1:0] sc;
    bit near;
    for (int p = 0; p < N; p++) begin
      near = 1'b0;
      for (int q = 0; q < N; q++) if (q != p && box[q] && m_lives[q] > 0) near = 1'b1;
      ex[p] = bul[p] && (hard || near);
      hit[p] = 1'b0;
      if (m_phase == 1) for (int s = 0; s < N; s++) if (m_frame[p][s]) hit[p] = 1'b1;
      al[p] = (m_lives[p] > 0);
      iv[p] = (m_inv[p] > 0);
      lv[p*LW +: LW] = LW'(m_lives[p]);
      sc[p*SW +: SW] = SW'(m_score[p]);
    end
    return {ex, des && (|bul), hit, al, iv, lv, sc, m_phase == 2, m_wv, PW'(m_win)};
  endfunction

  function automatic void model_step(input logic [N-1:0] box, bul, input logic fe, rs);
    int kills, n_alive, last;
    bit victim;
    if (m_phase != 2)
      for (int v = 0; v < N; v++)
        for (int s = 0; s < N; s++)
          if (s != v && box[v] && bul[s] && m_lives[v] > 0 && m_inv[v] == 0) m_pend[v][s] = 1'b1;
    if (m_phase == 0) begin
      if (fe) begin
        m_frame = m_pend;
        for (int v = 0; v < N; v++) for (int s = 0; s < N; s++) m_pend[v][s] = 1'b0;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      for (int v = 0; v < N; v++) begin
        victim = 1'b0;
        for (int s = 0; s < N; s++) if (m_frame[v][s]) victim = 1'b1;
        if (victim) begin
          if (m_lives[v] > 0) m_lives[v]--;
          m_inv[v] = INV;
        end else if (m_inv[v] > 0) begin
          m_inv[v]--;
        end
      end
      for (int s = 0; s < N; s++) begin
        kills = 0;
        for (int v = 0; v < N; v++) if (m_frame[v][s]) kills++;
        m_score[s] = (m_score[s] + kills > SMAX) ? SMAX : m_score[s] + kills;
      end
      for (int v = 0; v < N; v++) for (int s = 0; s < N; s++) m_frame[v][s] = 1'b0;
      n_alive = 0;
      last = 0;
      for (int p = 0; p < N; p++) if (m_lives[p] > 0) begin n_alive++; last = p; end
      if (n_alive <= 1) begin
        m_phase = 2;
        m_wv = (n_alive == 1);
        m_win = (n_alive == 1) ? last : 0;
      end else begin
        m_phase = 0;
      end
    end else if (rs) begin
      model_reset();
    end
  endfunction

  // driver tasks
  task automatic cyc(input logic [N-1:0] box, bul, input logic hard, des, fe, rs);
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    player_box_i = box;
    player_bullet_i = bul;
    all_hard_block_i = hard;
    destroyable_block_i = des;
    frame_end_i = fe;
    restart_i = rs;
    exp_q.push_back(model_expect(box, bul, hard, des));
    model_step(box, bul, fe, rs);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc('0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic end_frame();
    cyc('0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    rst_i = 1'b1;
    player_box_i = '0;
    player_bullet_i = '0;
    all_hard_block_i = 1'b0;
    destroyable_block_i = 1'b0;
    frame_end_i = 1'b0;
    restart_i = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst_i = 1'b0;
    model_reset();
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Repeated frames of the given pixel until every player in stop_dead is out or the game ends.
  task automatic attack(input logic [N-1:0] box, bul, input logic [N-1:0] stop_dead, input int max_frames);
    bit done;
    for (int f = 0; f < max_frames; f++) begin
      done = 1'b1;
      for (int p = 0; p < N; p++) if (stop_dead[p] && m_lives[p] > 0) done = 1'b0;
      if (done || m_phase == 2) break;
      cyc(box, bul, 1'b0, 1'b0, 1'b0, 1'b0);
      end_frame();
      idle(1);
    end
  endtask

  // scoreboard monitor
  string fname[10] = '{"explode", "wall", "player_hit", "alive", "invuln", "lives", "score",
                       "game_over", "winner_valid", "winner"};
  int fw[10] = '{N, 1, N, N, N, N*LW, N*SW, 1, 1, PW};

  initial begin
    logic [EW-1:0] e, a, mask;
    int pos;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {bullet_explode_o, bullet_collide_wall_o, player_hit_o, player_alive_o,
             player_invuln_o, player_lives_o, player_score_o, game_over_o,
             winner_valid_o, winner_o};
        pos = EW;
        for (int i = 0; i < 10; i++) begin
          pos -= fw[i];
          if (i == 9 && e[PW+1] && !e[PW]) continue;
          mask = {EW{1'b1}} >> (EW - fw[i]);
          n_cmp++;
          if (((e >> pos) & mask) !== ((a >> pos) & mask)) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", fname[i], $time,
                     (a >> pos) & mask, (e >> pos) & mask);
          end
        end
      end
    end
  end

  initial begin
    model_reset();
    do_reset(2);
    idle(1);
    chk("reset_lives", int'(player_lives_o), 8'hFF);
    chk("reset_score", int'(player_score_o), 0);
    chk("reset_alive", int'(player_alive_o), 4'hF);
    chk("reset_over", int'(game_over_o), 0);
    chk("reset_wv", int'(winner_valid_o), 0);

    // bullet 1 on tank 2
    cyc(4'b0100, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0);
    end_frame();
    idle(1);
    chk("s1_hit_pulse", int'(player_hit_o), 4'b0100);
    idle(1);
    chk("s1_hit_clear", int'(player_hit_o), 0);
    chk("s1_lives2", int'(player_lives_o[2*LW +: LW]), 2);
    chk("s1_score1", int'(player_score_o[1*SW +: SW]), 1);
    chk("s1_invuln2", int'(player_invuln_o), 4'b0100);

    // own tank, hard block, destroyable block
    cyc(4'b0001, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("own_tank_explode", int'(bullet_explode_o), 0);
    cyc(4'b0000, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("hard_explode", int'(bullet_explode_o), 4'b0001);
    cyc(4'b0000, 4'b0100, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("wall", int'(bullet_collide_wall_o), 1);
    end_frame();
    idle(2);
    chk("s2_lives", int'(player_lives_o), 8'hEF);

    // invulnerable tank 2 still explodes the bullet but keeps its lives
    cyc(4'b0100, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("invuln_explode", int'(bullet_explode_o), 4'b0010);
    end_frame();
    idle(2);
    chk("s3_lives", int'(player_lives_o), 8'hEF);

    // two shooters on tank 1, tank 1 shoots tank 0
    cyc(4'b0010, 4'b1001, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(4'b0001, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0);
    end_frame();
    idle(2);
    chk("s4_lives", int'(player_lives_o), 8'hEA);
    chk("s4_score", int'(player_score_o), 8'h49);

    // random pixels, frame ends and restarts
    for (int i = 0; i < 300; i++) begin
      cyc(4'($urandom_range(0, 15)),
          ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000,
          $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
          $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
    end

    // player 0 eliminates everyone; multi-victim credit saturates the score
    do_reset(1);
    attack(4'b1110, 4'b0001, 4'b1110, 400);
    idle(2);
    chk("win_over", int'(game_over_o), 1);
    chk("win_valid", int'(winner_valid_o), 1);
    chk("win_index", int'(winner_o), 0);
    chk("win_score_sat", int'(player_score_o[0 +: SW]), SMAX);
    cyc(4'b0000, 4'b0001, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("over_explode", int'(bullet_explode_o), 4'b0001);
    cyc('0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1);
    chk("restart_lives", int'(player_lives_o), 8'hFF);
    chk("restart_score", int'(player_score_o), 0);
    chk("restart_over", int'(game_over_o), 0);

    // players 2 and 3 out, then a mutual final kill is a draw
    attack(4'b1100, 4'b0001, 4'b1100, 400);
    attack(4'b0011, 4'b0011, 4'b0011, 400);
    idle(2);
    chk("draw_over", int'(game_over_o), 1);
    chk("draw_valid", int'(winner_valid_o), 0);
    chk("draw_alive", int'(player_alive_o), 0);
    cyc('0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1);

    // reset during resolution discards the pending hit
    cyc(4'b0100, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0);
    end_frame();
    do_reset(1);
    idle(1);
    chk("midres_lives", int'(player_lives_o), 8'hFF);
    chk("midres_hit", int'(player_hit_o), 0);
    end_frame();
    idle(3);

    @(negedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bullet_collide_mp.md
# bullet_collide_mp

Parametrised N-player bullet/collision resolver for the tank game, sitting between the pixel-level object renderers and the game-state logic. Per pixel it flags bullet explosions and destroyable-wall hits combinationally. Player-on-bullet hits are latched into a shooter/victim matrix across a frame and resolved once per frame at `frame_end_i`. Resolution updates lives, kill scores, respawn invulnerability and game-over/winner state.

## Interface
Parameters:
- `NUM_PLAYERS`, 4, number of players N (2..8).
- `START_LIVES`, 3, lives loaded at reset/restart (1..2^LIVES_W-1).
- `LIVES_W`, 2, lives counter width.
- `SCORE_W`, 8, per-player kill counter width, saturating.
- `INVULN_FRAMES`, 60, frames of invulnerability after a hit (≥1); `INVULN_W = $clog2(INVULN_FRAMES+1)`.

Ports (flattened vectors: player p at `[p*W +: W]`):
- `clk_i` in 1: system clock; all state on rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `frame_end_i` in 1: one-cycle pulse, last cycle of a frame.
- `restart_i` in 1: new game request, honoured only in OVER.
- `player_box_i` in N: current pixel inside player p's tank.
- `player_bullet_i` in N: current pixel inside player p's bullet.
- `all_hard_block_i` in 1: pixel on indestructible block/border.
- `destroyable_block_i` in 1: pixel on destroyable block.
- `bullet_explode_o` out N: combinational, bullet p must explode.
- `bullet_collide_wall_o` out 1: combinational, any bullet on destroyable block.
- `player_hit_o` out N: one-cycle pulse, p lost a life this resolution.
- `player_alive_o` out N: p has lives > 0.
- `player_invuln_o` out N: p's invulnerability counter nonzero.
- `player_lives_o` out N*LIVES_W: lives per player.
- `player_score_o` out N*SCORE_W: kills per player.
- `game_over_o` out 1: high in OVER.
- `winner_valid_o` out 1, `winner_o` out clog2(N): sole survivor index when game over; valid=0 on draw.

## Operation
- Explosion (comb): `bullet_explode_o[p] = player_bullet_i[p] & (all_hard_block_i | OR over q≠p of (player_box_i[q] & alive[q]))`. Own tank never explodes own bullet; dead tanks ignored; invulnerable tanks still explode bullets.
- `bullet_collide_wall_o = destroyable_block_i & |player_bullet_i`.
- Hit condition, pixel cycle: `player_box_i[v] & player_bullet_i[s] & s≠v & alive[v] & ~invuln[v]` sets `hit_q[v][s]` (sticky for the frame). Self-hits never recorded.
- States: PLAY → (frame_end_i) → RESOLVE → PLAY or OVER; OVER → (restart_i) → PLAY with full reload.
- RESOLVE uses the matrix including the `frame_end_i` cycle's pixel. Per victim v with any hit: lives-1 (saturate 0), `player_hit_o[v]`=1 for the RESOLVE cycle, invuln loaded with INVULN_FRAMES. Each shooter s gets +1 per distinct victim hit (saturate at 2^SCORE_W-1). Multiple shooters on one victim: one life lost, every shooter credited. Mutual hits both apply.
- Invuln counters of players not hit this frame decrement by 1 at each resolution while nonzero.
- After the update, alive count ≤1 → OVER. One survivor gives winner_valid_o=1 and winner_o=index; zero gives winner_valid_o=0. Otherwise → PLAY.
- Matrix clears on entry to RESOLVE. Pixels during the RESOLVE cycle belong to the next frame. In OVER no hits latch, lives/scores frozen, explosion outputs still active.
- `frame_end_i` during RESOLVE or OVER ignored. `restart_i` outside OVER ignored.

## Timing
- Reset values: lives=START_LIVES, alive=all 1, scores=0, invuln=0, hit matrix=0, player_hit_o=0, game_over_o=0, winner_valid_o=0, winner_o=0, state PLAY. Restart produces the same values.
- Explosion/wall outputs: zero latency, combinational from inputs.
- frame_end_i at cycle T: RESOLVE at T+1 with player_hit_o high during T+1. Lives/score/invuln/alive/game_over_o visible from T+2.
- rst_i overrides everything in the same edge, including mid-RESOLVE; no pending hits survive.

## Test plan
- N=4, reset → lives all 3, scores 0, alive=4'b1111, game_over_o=0, winner_valid_o=0.
- Bullet 1 on box 2 for one pixel, then frame_end_i → player_hit_o=4'b0100 for one cycle, lives[2]=2, score[1]=1, invuln[2]=1 for 60 frames, then 0.
- Bullets 0 and 3 both on box 1 in same frame, and bullet 1 on box 0 → lives[1]=2, lives[0]=2, score[0]=1, score[3]=1, score[1]=1.
- Bullet 0 on own box 0 → bullet_explode_o[0]=0, no hit. Bullet 0 on hard block → bullet_explode_o[0]=1. Bullet on destroyable block → bullet_collide_wall_o=1.
- Hit invulnerable player 2 again next frame → lives unchanged, bullet_explode_o still 1.
- Reduce players 1–3 to 0 lives with player 0 → game_over_o=1, winner_o=0, winner_valid_o=1. Final mutual kill of the last two → winner_valid_o=0. restart_i → reset values. Score saturation at 255 holds.
